// File: rtl/uart_rx_delay_cfg.sv
// UART receiver for 8-byte delay-RAM configuration frames: header, target ID, channel,
// address, big-endian delay, reserved byte and XOR checksum; decoded into per-channel RAM writes.
module uart_rx_delay_cfg #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DELAY_W      = 16,
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic               I_clk_10M,
  input  logic               I_rst_n,
  input  logic               rxb,
  input  logic [4:0]         GA,
  output logic [N_CH-1:0]    O_WEA,
  output logic [ADDR_W-1:0]  O_WRITE_ADDR,
  output logic [DELAY_W-1:0] O_WRITE_DELAY,
  output logic               O_FRAME_OK,
  output logic               O_ERR,
  output logic [1:0]         O_ERR_CODE,
  output logic               O_BUSY
);

  localparam int unsigned CntW        = $clog2(CLKS_PER_BIT);
  localparam int unsigned TimeoutClks = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned GapW        = $clog2(TimeoutClks + 1);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GapW-1:0] GapMax  = GapW'(TimeoutClks);
  localparam logic [7:0]      Header  = 8'hA5;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  rx_state_e           state_q, state_d;
  logic                sync1_q, sync2_q, rx_prev_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          xor_q, xor_d;
  logic [4:0]          tgt_q, tgt_d;
  logic [7:0]          ch_q, ch_d;
  logic [7:0]          addr_q, addr_d;
  logic [15:0]         dly_q, dly_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic [N_CH-1:0]     wea_q, wea_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DELAY_W-1:0]  wdelay_q, wdelay_d;
  logic                frame_ok_q, frame_ok_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                rx, fall, byte_done, frame_err, timeout;
  logic [N_CH-1:0]     sel;

  assign rx   = sync2_q;
  assign fall = rx_prev_q & ~sync2_q;

  // Bit-level receiver
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfEnd) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitEnd) begin
          state_d   = StIdle;
          byte_done = rx;
          frame_err = ~rx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Channel decode: 0xFF selects every channel, out-of-range selects none
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sel[i] = (ch_q == 8'hFF) || (ch_q == 8'(i));
    end
  end

  // Only the idle gap between bytes of a started frame counts toward the timeout
  assign timeout = (byte_cnt_q != 3'd0) && (state_q == StIdle) && !fall && (gap_q == GapMax);

  // Frame assembly and write/error generation
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    xor_d      = xor_q;
    tgt_d      = tgt_q;
    ch_d       = ch_q;
    addr_d     = addr_q;
    dly_d      = dly_q;
    gap_d      = gap_q;
    wea_d      = '0;
    waddr_d    = waddr_q;
    wdelay_d   = wdelay_q;
    frame_ok_d = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (byte_done) begin
      gap_d = '0;
    end else if ((state_q == StIdle) && (byte_cnt_q != 3'd0) && (gap_q != GapMax)) begin
      gap_d = gap_q + 1'b1;
    end

    if (frame_err) begin
      err_d      = 1'b1;
      err_code_d = 2'd0;
      byte_cnt_d = '0;
    end else if (timeout) begin
      err_d      = 1'b1;
      err_code_d = 2'd2;
      byte_cnt_d = '0;
    end else if (byte_done) begin
      case (byte_cnt_q)
        3'd0: begin
          if (shift_q == Header) begin
            xor_d      = Header;
            byte_cnt_d = 3'd1;
          end
        end
        3'd7: begin
          byte_cnt_d = '0;
          if (xor_q != shift_q) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else if ((tgt_q == GA) || (tgt_q == 5'h1F)) begin
            if (sel != '0) begin
              wea_d      = sel;
              waddr_d    = addr_q[ADDR_W-1:0];
              wdelay_d   = dly_q[DELAY_W-1:0];
              frame_ok_d = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_code_d = 2'd3;
            end
          end
        end
        default: begin
          xor_d      = xor_q ^ shift_q;
          byte_cnt_d = byte_cnt_q + 1'b1;
          case (byte_cnt_q)
            3'd1:    tgt_d         = shift_q[4:0];
            3'd2:    ch_d          = shift_q;
            3'd3:    addr_d        = shift_q;
            3'd4:    dly_d[15:8]   = shift_q;
            3'd5:    dly_d[7:0]    = shift_q;
            default: ;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      xor_q      <= '0;
      tgt_q      <= '0;
      ch_q       <= '0;
      addr_q     <= '0;
      dly_q      <= '0;
      gap_q      <= '0;
      wea_q      <= '0;
      waddr_q    <= '0;
      wdelay_q   <= '0;
      frame_ok_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      sync1_q    <= rxb;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      xor_q      <= xor_d;
      tgt_q      <= tgt_d;
      ch_q       <= ch_d;
      addr_q     <= addr_d;
      dly_q      <= dly_d;
      gap_q      <= gap_d;
      wea_q      <= wea_d;
      waddr_q    <= waddr_d;
      wdelay_q   <= wdelay_d;
      frame_ok_q <= frame_ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign O_WEA         = wea_q;
  assign O_WRITE_ADDR  = waddr_q;
  assign O_WRITE_DELAY = wdelay_q;
  assign O_FRAME_OK    = frame_ok_q;
  assign O_ERR         = err_q;
  assign O_ERR_CODE    = err_code_q;
  assign O_BUSY        = (byte_cnt_q != 3'd0);

endmodule

// File: tb/tb_uart_rx_delay_cfg.sv
// Bench for uart_rx_delay_cfg: fixed frame table, hand-written corner sequences and random
// frames checked against a frame-level reference model.
module tb_uart_rx_delay_cfg;
  localparam int          CPB   = 10;
  localparam int          NCH   = 4;
  localparam logic [4:0]  MY_GA = 5'd14;

  typedef logic [0:7][7:0] frame_t;
  typedef struct {
    int          kind;  // 0 none, 1 write, 2 error
    logic [3:0]  wea;
    logic [7:0]  addr;
    logic [15:0] dly;
    logic [1:0]  code;
  } exp_t;
  typedef struct {
    string  name;
    frame_t f;
    exp_t   e;
  } vec_t;
  typedef struct {
    logic [3:0]  wea;
    logic [7:0]  addr;
    logic [15:0] dly;
    logic        fok;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxb = 1'b1;
  logic [4:0]  ga = MY_GA;
  logic [3:0]  O_WEA;
  logic [7:0]  O_WRITE_ADDR;
  logic [15:0] O_WRITE_DELAY;
  logic        O_FRAME_OK, O_ERR, O_BUSY;
  logic [1:0]  O_ERR_CODE;

  int errors = 0;
  int checks = 0;
  wr_t        wr_q[$];
  logic [1:0] err_q[$];
  logic [7:0]  last_addr = '0;
  logic [15:0] last_dly = '0;
  logic [1:0]  last_code = '0;

  uart_rx_delay_cfg #(
    .N_CH(NCH), .ADDR_W(8), .DELAY_W(16), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(40)
  ) dut (
    .I_clk_10M(clk), .I_rst_n(rst_n), .rxb(rxb), .GA(ga),
    .O_WEA(O_WEA), .O_WRITE_ADDR(O_WRITE_ADDR), .O_WRITE_DELAY(O_WRITE_DELAY),
    .O_FRAME_OK(O_FRAME_OK), .O_ERR(O_ERR), .O_ERR_CODE(O_ERR_CODE), .O_BUSY(O_BUSY)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (O_ERR || (O_WEA != '0))
        check("err_wea_exclusive", {63'b0, O_ERR && (O_WEA != '0)}, 64'd0);
      if ((O_WEA != '0) || O_FRAME_OK)
        wr_q.push_back('{wea: O_WEA, addr: O_WRITE_ADDR, dly: O_WRITE_DELAY, fok: O_FRAME_OK});
      if (O_ERR) err_q.push_back(O_ERR_CODE);
    end
  end

  function automatic logic [7:0] xor7(input frame_t f);
    logic [7:0] x = '0;
    for (int i = 0; i < 7; i++) x ^= f[i];
    return x;
  endfunction

  // Reference: outcome of one complete frame from the frame rules alone
  function automatic exp_t model(input frame_t f);
    exp_t e = '{kind: 0, wea: '0, addr: f[3], dly: {f[4], f[5]}, code: '0};
    if (xor7(f) != f[7]) begin
      e.kind = 2; e.code = 2'd1;
    end else if ((f[1][4:0] == MY_GA) || (f[1][4:0] == 5'h1F)) begin
      if (f[2] == 8'hFF) begin
        e.kind = 1; e.wea = 4'hF;
      end else if (int'(f[2]) < NCH) begin
        e.kind = 1; e.wea = 4'(1 << f[2]);
      end else begin
        e.kind = 2; e.code = 2'd3;
      end
    end
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxb = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxb = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxb = stop_bit;
    repeat (CPB) @(negedge clk);
    rxb = 1'b1;
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < 8; i++) send_byte(f[i], 1'b1);
  endtask

  task automatic check_outcome(input string tag, input exp_t e);
    check({tag, "_writes"}, 64'(wr_q.size()), 64'(e.kind == 1));
    if ((e.kind == 1) && (wr_q.size() > 0)) begin
      check({tag, "_wea"}, 64'(wr_q[0].wea), 64'(e.wea));
      check({tag, "_addr"}, 64'(wr_q[0].addr), 64'(e.addr));
      check({tag, "_delay"}, 64'(wr_q[0].dly), 64'(e.dly));
      check({tag, "_frame_ok"}, 64'(wr_q[0].fok), 64'd1);
      last_addr = e.addr;
      last_dly  = e.dly;
    end
    check({tag, "_errs"}, 64'(err_q.size()), 64'(e.kind == 2));
    if ((e.kind == 2) && (err_q.size() > 0)) begin
      check({tag, "_code"}, 64'(err_q[0]), 64'(e.code));
      last_code = e.code;
    end
    check({tag, "_held"}, {38'b0, O_WRITE_ADDR, O_WRITE_DELAY, O_ERR_CODE},
          {38'b0, last_addr, last_dly, last_code});
    wr_q.delete();
    err_q.delete();
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl[6];
    frame_t f;
    exp_t   e;
    exp_t   st_exp[4];

    tbl[0] = '{"unicast",   {8'hA5, 8'h0E, 8'h01, 8'h03, 8'h00, 8'h14, 8'h00, 8'hBD},
               '{1, 4'b0010, 8'h03, 16'h0014, 2'd0}};
    tbl[1] = '{"broadcast", {8'hA5, 8'h1F, 8'hFF, 8'h05, 8'h00, 8'h28, 8'h00, 8'h68},
               '{1, 4'b1111, 8'h05, 16'h0028, 2'd0}};
    tbl[2] = '{"other_id",  {8'hA5, 8'h0D, 8'h00, 8'h01, 8'h00, 8'h0A, 8'h00, 8'hA3},
               '{0, 4'b0000, 8'h00, 16'h0000, 2'd0}};
    tbl[3] = '{"bad_xor",   {8'hA5, 8'h0E, 8'h01, 8'h03, 8'h00, 8'h14, 8'h00, 8'h00},
               '{2, 4'b0000, 8'h00, 16'h0000, 2'd1}};
    tbl[4] = '{"bad_chan",  {8'hA5, 8'h0E, 8'h04, 8'h03, 8'h00, 8'h14, 8'h00, 8'hB8},
               '{2, 4'b0000, 8'h00, 16'h0000, 2'd3}};
    tbl[5] = '{"id_upper",  {8'hA5, 8'h2E, 8'h00, 8'h07, 8'h12, 8'h34, 8'h00, 8'hAA},
               '{1, 4'b0001, 8'h07, 16'h1234, 2'd0}};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {37'b0, O_WEA, O_WRITE_ADDR, O_WRITE_DELAY, O_FRAME_OK, O_ERR,
                            O_ERR_CODE, O_BUSY}, 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (tbl[i]) begin
      send_frame(tbl[i].f);
      repeat (20) @(negedge clk);
      check_outcome(tbl[i].name, tbl[i].e);
    end

    // Framing error on B3
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0E, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h03, 1'b0);
    repeat (20) @(negedge clk);
    check_outcome("framing", '{2, 4'b0, 8'h0, 16'h0, 2'd0});
    check("framing_busy", 64'(O_BUSY), 64'd0);

    // Junk byte, partial frame, then idle past the timeout
    send_byte(8'h3C, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0E, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (20) @(negedge clk);
    check("timeout_busy_mid", 64'(O_BUSY), 64'd1);
    repeat (480) @(negedge clk);
    check_outcome("timeout", '{2, 4'b0, 8'h0, 16'h0, 2'd2});
    check("timeout_busy_after", 64'(O_BUSY), 64'd0);
    f = {8'hA5, 8'h0E, 8'h02, 8'h09, 8'h01, 8'h02, 8'h00, 8'h00};
    f[7] = xor7(f);
    send_frame(f);
    repeat (20) @(negedge clk);
    check_outcome("resync", '{1, 4'b0100, 8'h09, 16'h0102, 2'd0});

    // Reset during B4
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0E, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h03, 1'b1);
    rxb = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_busy_mid", 64'(O_BUSY), 64'd1);
    rst_n = 1'b0;
    rxb   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_outputs", {37'b0, O_WEA, O_WRITE_ADDR, O_WRITE_DELAY, O_FRAME_OK, O_ERR,
                              O_ERR_CODE, O_BUSY}, 64'd0);
    rst_n = 1'b1;
    last_addr = '0;
    last_dly  = '0;
    last_code = '0;
    repeat (30) @(negedge clk);
    check_outcome("rst_mid", '{0, 4'b0, 8'h0, 16'h0, 2'd0});

    // Four back-to-back frames, zero gap
    for (int i = 0; i < 4; i++) begin
      f = {8'hA5, 8'h0E, 8'(i), 8'(8'h20 + i), 8'h00, 8'((i + 1) * 10), 8'h00, 8'h00};
      f[7] = xor7(f);
      st_exp[i] = model(f);
      send_frame(f);
    end
    repeat (20) @(negedge clk);
    check("stream_writes", 64'(wr_q.size()), 64'd4);
    check("stream_errs", 64'(err_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (wr_q.size() > i) begin
        check("stream_wea", 64'(wr_q[i].wea), 64'(st_exp[i].wea));
        check("stream_addr", 64'(wr_q[i].addr), 64'(st_exp[i].addr));
        check("stream_delay", 64'(wr_q[i].dly), 64'(st_exp[i].dly));
      end
    end
    last_addr = st_exp[3].addr;
    last_dly  = st_exp[3].dly;
    wr_q.delete();
    err_q.delete();

    // Random frames against the reference model
    for (int n = 0; n < 24; n++) begin
      logic [7:0] g;
      int         sel_t, sel_c;
      sel_t = $urandom_range(0, 3);
      sel_c = $urandom_range(0, 9);
      f[0] = 8'hA5;
      f[1] = (sel_t == 0) ? 8'(MY_GA) : (sel_t == 1) ? 8'h1F :
             (sel_t == 2) ? 8'($urandom_range(0, 255)) : {3'($urandom_range(0, 7)), MY_GA};
      f[2] = (sel_c < 6) ? 8'($urandom_range(0, 3)) : (sel_c < 8) ? 8'hFF :
             8'($urandom_range(4, 254));
      f[3] = 8'($urandom_range(0, 255));
      f[4] = 8'($urandom_range(0, 255));
      f[5] = 8'($urandom_range(0, 255));
      f[6] = 8'($urandom_range(0, 255));
      f[7] = xor7(f);
      if ($urandom_range(0, 4) == 0) f[7] ^= 8'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1'b1);
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
      e = model(f);
      send_frame(f);
      repeat (20) @(negedge clk);
      check_outcome("random", e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_delay_cfg.md
UART_RX_DELAY_CFG -- requirements
Module: uart_rx_delay_cfg

Interface
REQ-001 The block SHALL take parameter N_CH, default 4, as the number of delay-RAM channels (1..32).
REQ-002 The block SHALL take parameter ADDR_W, default 8, as the delay-RAM address width (1..8).
REQ-003 The block SHALL take parameter DELAY_W, default 16, as the delay value width (1..16).
REQ-004 The block SHALL take parameter CLKS_PER_BIT, default 10, as clocks per UART bit (>=4).
REQ-005 The block SHALL take parameter TIMEOUT_BITS, default 40, as the maximum idle bit-times allowed between bytes of one frame.
REQ-006 The block SHALL use one clock; reset SHALL be asynchronous and active-low; ports I_clk_10M, I_rst_n.
REQ-007 The block SHALL have the following ports:
- I_clk_10M  in  1  system clock
- I_rst_n  in  1  async active-low reset
- rxb  in  1  UART serial input, asynchronous, idle high
- GA  in  5  own module ID (PXIe geographic address)
- O_WEA  out  N_CH  per-channel RAM write enable, one-cycle pulse
- O_WRITE_ADDR  out  ADDR_W  RAM write address, shared by all channels
- O_WRITE_DELAY  out  DELAY_W  RAM write data, shared by all channels
- O_FRAME_OK  out  1  one-cycle pulse per accepted frame
- O_ERR  out  1  one-cycle error pulse
- O_ERR_CODE  out  2  error cause, held until the next error
- O_BUSY  out  1  high while a frame is partially received

Function
REQ-008 rxb SHALL pass through a 2-flop synchronizer before any use.
REQ-009 The bit receiver SHALL use states IDLE -> START -> DATA -> STOP -> IDLE:
- IDLE->START on a synchronized falling edge.
- START checks the line at CLKS_PER_BIT/2; if the line is high, return to IDLE (glitch), otherwise go to DATA.
- DATA samples 8 bits LSB first, each CLKS_PER_BIT apart.
- STOP samples one bit; high = byte valid; low = framing error (code 0), discard the partial frame, return to IDLE.
REQ-010 A frame SHALL be 8 bytes (B0..B7):
- B0 = 0xA5 header
- B1[4:0] = target ID
- B2 = channel
- B3 = address
- B4:B5 = delay, big-endian
- B6 = reserved
- B7 = XOR of B0..B6
REQ-011 A B0 value other than 0xA5 SHALL be dropped silently; the byte counter SHALL stay at 0 (resync).
REQ-012 O_BUSY SHALL be high from acceptance of B0 until frame completion or abort.
REQ-013 If the gap from one byte's stop sample to the next start edge exceeds TIMEOUT_BITS*CLKS_PER_BIT clocks mid-frame, the frame SHALL be discarded with error code 2.
REQ-014 On checksum mismatch the block SHALL raise error code 1 and issue no write.
REQ-015 A frame SHALL be addressed to this module when B1[4:0]==GA or B1[4:0]==0x1F.
REQ-016 A frame not addressed to this module SHALL be dropped silently: no write, no error, no O_FRAME_OK.
REQ-017 B2 < N_CH SHALL set only O_WEA[B2]; B2 == 0xFF SHALL set all O_WEA bits (broadcast).
REQ-018 Any other B2 value SHALL raise error code 3 and issue no write.
REQ-019 O_WRITE_ADDR SHALL be B3[ADDR_W-1:0]; O_WRITE_DELAY SHALL be {B4,B5}[DELAY_W-1:0]; upper bits are truncated silently.
REQ-020 For an accepted frame, O_WEA, O_WRITE_ADDR, O_WRITE_DELAY and O_FRAME_OK SHALL be valid in exactly one cycle, the cycle after B7's stop-bit sample.
REQ-021 O_WRITE_ADDR and O_WRITE_DELAY SHALL hold their values until the next accepted frame.
REQ-022 O_ERR SHALL pulse for one cycle, in the cycle after the error is detected.
REQ-023 O_ERR and O_WEA SHALL never be high in the same cycle.
REQ-024 A new start edge arriving during a write cycle SHALL be received normally (back-to-back frames, zero gap).

Reset
REQ-025 While I_rst_n is low, all of the following SHALL be 0: O_WEA, O_WRITE_ADDR, O_WRITE_DELAY, O_FRAME_OK, O_ERR, O_ERR_CODE, O_BUSY.
REQ-026 While I_rst_n is low, the bit FSM SHALL be in IDLE, the byte counter 0, and the synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no write and no error pulse.
REQ-028 After reset deassertion, the first start edge SHALL be recognized no earlier than the third clock.

Verification
(GA=14, CLKS_PER_BIT=10, defaults for other parameters.)
REQ-029 Unicast: send A5 0E 01 03 00 14 00 BD -> one-cycle O_WEA=4'b0010, ADDR=0x03, DELAY=0x0014, O_FRAME_OK=1, O_ERR never high.
REQ-030 Broadcast: send A5 1F FF 05 00 28 00 68 -> O_WEA=4'b1111, ADDR=0x05, DELAY=0x0028; then A5 0D 00 01 00 0A 00 (valid XOR) -> no write, no error.
REQ-031 Errors:
- Frame of REQ-029 with B7=00 -> O_ERR pulse, CODE=1, no O_WEA.
- Valid-checksum frame with B2=0x04 -> CODE=3.
- Stop bit forced low on B3 -> CODE=0.
REQ-032 Timeout/resync: send 3C then A5 0E 02, idle 500 clocks -> CODE=2, O_BUSY falls; then a full valid frame for channel 2 -> O_WEA=4'b0100.
REQ-033 Reset/stream: pulse I_rst_n low during B4 -> all outputs 0, no write; then four back-to-back frames for channels 0..3 with delays 10,20,30,40 -> four single writes, in order, with correct values.
